// File: rtl/arq_tx_buffer_pkg.sv
// Shared types and helpers for the stop-and-wait ARQ transmit buffer.
package arq_tx_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } arq_state_t;

  localparam int RETRY_W = 4;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arq_tx_buffer_fifo.sv
// Frame store for the ARQ buffer: write side from upstream, head released only by an explicit free strobe.
module arq_tx_buffer_fifo
  import arq_tx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_valid,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_free,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  w_wr_en;

  assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Fullness is judged on registered pointers, so a same-cycle free cannot make room.
  assign w_wr_en = i_wr_valid && !o_full;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_free) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/arq_tx_buffer.sv
// Stop-and-wait ARQ transmit buffer: FIFO of frames, head sent with a sequence number and held until ACK,
// retransmitted on NACK/timeout, dropped after MAX_RETRY retransmissions.
module arq_tx_buffer
  import arq_tx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SEQ_WIDTH  = 2,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [SEQ_WIDTH-1:0]    tx_seq,
  input  logic                    tx_ready,
  input  logic                    rx_ack,
  input  logic                    rx_nack,
  output logic                    done_pulse,
  output logic                    drop_pulse,
  output logic [RETRY_W-1:0]      retry_cnt,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int TW = $clog2(TIMEOUT);

  arq_state_t           r_state, w_state_next;
  logic [SEQ_WIDTH-1:0] r_seq, w_seq_next;
  logic [RETRY_W-1:0]   r_retry, w_retry_next;
  logic [TW-1:0]        r_timer, w_timer_next;
  logic                 r_done, w_done_next;
  logic                 r_drop, w_drop_next;
  logic                 w_free;
  logic                 w_full;
  logic                 w_empty;

  arq_tx_buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .i_free     (w_free),
    .o_rd_data  (tx_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (count)
  );

  assign wr_ready   = !w_full;
  assign tx_valid   = (r_state == ST_SEND);
  assign tx_seq     = r_seq;
  assign retry_cnt  = r_retry;
  assign done_pulse = r_done;
  assign drop_pulse = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seq   <= '0;
      r_retry <= '0;
      r_timer <= '0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_seq   <= w_seq_next;
      r_retry <= w_retry_next;
      r_timer <= w_timer_next;
      r_done  <= w_done_next;
      r_drop  <= w_drop_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_seq_next   = r_seq;
    w_retry_next = r_retry;
    w_timer_next = r_timer;
    w_done_next  = 1'b0;
    w_drop_next  = 1'b0;
    w_free       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          w_state_next = ST_WAIT;
          w_timer_next = '0;
        end
      end
      ST_WAIT: begin
        w_timer_next = r_timer + 1'b1;
        // ACK takes priority over a simultaneous NACK.
        if (rx_ack) begin
          w_free       = 1'b1;
          w_seq_next   = r_seq + 1'b1;
          w_retry_next = '0;
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end else if (rx_nack || (r_timer == TW'(TIMEOUT - 1))) begin
          if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_retry_next = r_retry + 1'b1;
            w_state_next = ST_SEND;
          end else begin
            w_free       = 1'b1;
            w_seq_next   = r_seq + 1'b1;
            w_retry_next = '0;
            w_drop_next  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_arq_tx_buffer.sv
// Self-checking bench for arq_tx_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_arq_tx_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int SW    = 2;
  localparam int MAXR  = 3;
  localparam int TO    = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_valid;
  logic [DW-1:0]          wr_data;
  logic                   wr_ready;
  logic                   tx_valid;
  logic [DW-1:0]          tx_data;
  logic [SW-1:0]          tx_seq;
  logic                   tx_ready;
  logic                   rx_ack;
  logic                   rx_nack;
  logic                   done_pulse;
  logic                   drop_pulse;
  logic [3:0]             retry_cnt;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  arq_tx_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SEQ_WIDTH  (SW),
    .MAX_RETRY  (MAXR),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_seq     (tx_seq),
    .tx_ready   (tx_ready),
    .rx_ack     (rx_ack),
    .rx_nack    (rx_nack),
    .done_pulse (done_pulse),
    .drop_pulse (drop_pulse),
    .retry_cnt  (retry_cnt),
    .count      (count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of pending frames, "presenting" and "awaiting response" flags, counters.
  logic [DW-1:0] q[$];
  int m_seq, m_retry, m_timer;
  bit m_tx, m_out, m_done, m_drop;

  int sends_seen, dones_seen, drops_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_seq = 0; m_retry = 0; m_timer = 0;
    m_tx = 0; m_out = 0; m_done = 0; m_drop = 0;
  endtask

  task automatic check_all();
    chk("wr_ready",   32'(wr_ready),   32'(q.size() < DEPTH));
    chk("tx_valid",   32'(tx_valid),   32'(m_tx));
    if (m_tx) chk("tx_data", 32'(tx_data), 32'(q[0]));
    chk("tx_seq",     32'(tx_seq),     32'(m_seq));
    chk("retry_cnt",  32'(retry_cnt),  32'(m_retry));
    chk("count",      32'(count),      32'(q.size()));
    chk("done_pulse", 32'(done_pulse), 32'(m_done));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
  endtask

  task automatic model_advance(input bit wv, input logic [DW-1:0] wd, input bit tr, input bit ack, input bit nack);
    bit accept;
    bit free;
    accept = wv && (q.size() < DEPTH);
    free   = 0;
    m_done = 0;
    m_drop = 0;
    if (!m_tx && !m_out) begin
      if (q.size() > 0) m_tx = 1;
    end else if (m_tx) begin
      if (tr) begin
        m_tx = 0; m_out = 1; m_timer = 0;
      end
    end else begin
      if (ack) begin
        free = 1; m_seq = (m_seq + 1) % (1 << SW); m_retry = 0; m_done = 1; m_out = 0;
      end else if (nack || m_timer == TO - 1) begin
        m_out = 0;
        if (m_retry < MAXR) begin
          m_retry++; m_tx = 1;
        end else begin
          free = 1; m_seq = (m_seq + 1) % (1 << SW); m_retry = 0; m_drop = 1;
        end
      end else begin
        m_timer++;
      end
    end
    if (free) void'(q.pop_front());
    if (accept) q.push_back(wd);
  endtask

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit tr, input bit ack, input bit nack);
    wr_valid = wv; wr_data = wd; tx_ready = tr; rx_ack = ack; rx_nack = nack;
    check_all();
    if (tx_valid && tx_ready) sends_seen++;
    if (done_pulse) dones_seen++;
    if (drop_pulse) drops_seen++;
    model_advance(wv, wd, tr, ack, nack);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE; tx_ready = 1'b0; rx_ack = 1'b0; rx_nack = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0; wr_valid = 1'b0;
  endtask

  // Wait for the head frame to be presented, hand it off, then answer on the third WAIT cycle.
  task automatic serve(input bit ack, input bit nack, input bit wv, input logic [DW-1:0] wd);
    for (int i = 0; i < 40 && !tx_valid; i++) step(0, '0, 0, 0, 0);
    chk("reach_send", 32'(tx_valid), 32'd1);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(wv, wd, 0, ack, nack);
    step(0, '0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0, p0;
    model_clear();
    sends_seen = 0; dones_seen = 0; drops_seen = 0;
    @(posedge clk);
    #1;
    do_reset();

    // 1: single frame, ACK three cycles after handshake
    d0 = dones_seen;
    step(1, 8'hA5, 0, 0, 0);
    chk("t1_count_after_write", 32'(count), 32'd1);
    step(0, '0, 0, 0, 0);
    chk("t1_latency_tx_valid", 32'(tx_valid), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_tx_seq0", 32'(tx_seq), 32'd0);
    serve(1, 0, 0, '0);
    chk("t1_done_once", 32'(dones_seen - d0), 32'd1);
    chk("t1_seq_after", 32'(tx_seq), 32'd1);
    chk("t1_count_after", 32'(count), 32'd0);

    // 2: NACK twice then ACK
    d0 = dones_seen; s0 = sends_seen;
    step(1, 8'h11, 0, 0, 0);
    serve(0, 1, 0, '0);
    serve(0, 1, 0, '0);
    chk("t2_retry2", 32'(retry_cnt), 32'd2);
    serve(1, 0, 0, '0);
    chk("t2_sends", 32'(sends_seen - s0), 32'd3);
    chk("t2_done_once", 32'(dones_seen - d0), 32'd1);
    chk("t2_retry_clr", 32'(retry_cnt), 32'd0);

    // 3: no response, frame dropped after MAX_RETRY retransmissions
    p0 = drops_seen; s0 = sends_seen;
    step(1, 8'h22, 1, 0, 0);
    for (int i = 0; i < 80; i++) step(0, '0, 1, 0, 0);
    chk("t3_sends", 32'(sends_seen - s0), 32'd4);
    chk("t3_drop_once", 32'(drops_seen - p0), 32'd1);
    chk("t3_count", 32'(count), 32'd0);

    // 4: fill, overflow rejected, ACK with same-cycle write, ordered drain across pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    chk("t4_full", 32'(wr_ready), 32'd0);
    step(1, 8'h99, 0, 0, 0);
    chk("t4_overflow_ignored", 32'(count), 32'd8);
    serve(1, 0, 1, 8'h38);
    chk("t4_write_rejected_when_full", 32'(count), 32'd7);
    serve(1, 0, 1, 8'h39);
    chk("t4_ack_write_count_same", 32'(count), 32'd7);
    for (int i = 0; i < 12 && q.size() > 0; i++) serve(1, 0, 0, '0);
    chk("t4_drained", 32'(count), 32'd0);

    // 5: ACK+NACK together acts as ACK; responses outside WAIT ignored
    d0 = dones_seen;
    step(1, 8'h55, 0, 0, 0);
    serve(1, 1, 0, '0);
    chk("t5_ack_wins", 32'(dones_seen - d0), 32'd1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    step(1, 8'h66, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 1);
    chk("t5_send_ignores_ack", 32'(tx_valid), 32'd1);
    serve(1, 0, 0, '0);

    // 6: reset while waiting with 5 entries
    for (int i = 0; i < 5; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    chk("t6_count_before", 32'(count), 32'd5);
    do_reset();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_tx_seq", 32'(tx_seq), 32'd0);
    chk("t6_wr_ready", 32'(wr_ready), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 1) == 1), 8'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
